arbitro_bus_es: RTL and testbench

//  Round-robin arbiter for the shared 16-bit peripheral I/O bus (direcciones/datos)
//  of the single-cycle CPU. Shares the bus between NREQ masters (CPU, DMA, debug port,
//  ...), muxes the owner's address/write data/write enable onto it, and revokes

---
 rtl/arbitro_bus_es_pkg.sv | 12 +
 rtl/arb_defs.vh | 12 +
 rtl/arbitro_bus_es_rr_pick.sv | 31 +++
 rtl/arbitro_bus_es.sv | 110 +++++++++++
 tb/tb_arbitro_bus_es.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/arbitro_bus_es_pkg.sv
// Types shared by the peripheral-bus arbiter and its rotating-priority selector.
`include "arb_defs.vh"

package arbitro_bus_es_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = `ARB_IDLE,
    ST_OWNED = `ARB_OWNED,
    ST_TURN  = `ARB_TURN
  } arb_state_t;

endpackage

// File: rtl/arb_defs.vh
// Shared encodings and width macros for the arbitro_bus_es arbiter.
`ifndef ARB_DEFS_VH
`define ARB_DEFS_VH

`define ARB_IDLE  2'd0
`define ARB_OWNED 2'd1
`define ARB_TURN  2'd2

`define ID_W  ($clog2(NREQ))
`define CNT_W ($clog2(MAX_HOLD+1))

`endif

// File: rtl/arbitro_bus_es_rr_pick.sv
// Combinational rotating-priority selector: first set req bit after last_owner, wrapping.
`include "arb_defs.vh"

module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [`ID_W-1:0]   last_owner,
  output logic               any,
  output logic [`ID_W-1:0]   win_id
);

  localparam int IW = `ID_W;

  logic found;

  always_comb begin
    any    = |req;
    win_id = '0;
    found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(last_owner) + i) % NREQ;
      if (!found && req[idx]) begin
        win_id = IW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_bus_es.sv
// Round-robin owner arbitration for the shared peripheral I/O bus, with hold-time preemption.
`include "arb_defs.vh"

module arbitro_bus_es
  import arbitro_bus_es_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  parameter int DW       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [NREQ*DW-1:0]  addr_in,
  input  logic [NREQ*DW-1:0]  wdata_in,
  input  logic [NREQ-1:0]     we_in,
  output logic [NREQ-1:0]     gnt,
  output logic [`ID_W-1:0]    gnt_id,
  output logic                busy,
  output logic [DW-1:0]       bus_addr,
  output logic [DW-1:0]       bus_wdata,
  output logic                bus_we,
  output logic                timeout_err
);

  localparam int IW = `ID_W;
  localparam int CW = `CNT_W;

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [IW-1:0]   last_owner_q, last_owner_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            timeout_q, timeout_d;

  logic            pick_any;
  logic [IW-1:0]   pick_id;
  logic [NREQ-1:0] owner_oh;
  logic            others_wait;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .any        (pick_any),
    .win_id     (pick_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_id_q     <= '0;
      last_owner_q <= IW'(NREQ - 1);
      hold_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_id_q     <= gnt_id_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign owner_oh    = NREQ'(1) << gnt_id_q;
  assign others_wait = |(req & ~owner_oh);

  // last_owner is updated on the way into TURN so the dead cycle already arbitrates
  // with the rotated priority; >= keeps timeout live once the counter has saturated.
  always_comb begin
    state_d      = state_q;
    gnt_id_d     = gnt_id_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        hold_cnt_d = '0;
        if (pick_any) begin
          state_d  = ST_OWNED;
          gnt_id_d = pick_id;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_OWNED: begin
        if (hold_cnt_q != CW'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + CW'(1);
        if (!req[gnt_id_q]) begin
          state_d      = ST_TURN;
          last_owner_d = gnt_id_q;
        end else if (hold_cnt_q >= CW'(MAX_HOLD - 1) && !lock[gnt_id_q] && others_wait) begin
          state_d      = ST_TURN;
          last_owner_d = gnt_id_q;
          timeout_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == ST_OWNED);
    gnt         = busy ? owner_oh : '0;
    gnt_id      = gnt_id_q;
    bus_addr    = busy ? addr_in[int'(gnt_id_q)*DW +: DW]  : '0;
    bus_wdata   = busy ? wdata_in[int'(gnt_id_q)*DW +: DW] : '0;
    bus_we      = busy & we_in[gnt_id_q];
    timeout_err = timeout_q;
  end

endmodule

// File: tb/tb_arbitro_bus_es.sv
// Directed checks of the peripheral-bus arbiter: reset, grants, rotation, timeout, lock, async reset.
module tb_arbitro_bus_es;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     lock;
  logic [NREQ*DW-1:0]  addr_in;
  logic [NREQ*DW-1:0]  wdata_in;
  logic [NREQ-1:0]     we_in;
  logic [NREQ-1:0]     gnt;
  logic [1:0]          gnt_id;
  logic                busy;
  logic [DW-1:0]       bus_addr;
  logic [DW-1:0]       bus_wdata;
  logic                bus_we;
  logic                timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  arbitro_bus_es #(.NREQ(NREQ), .MAX_HOLD(16), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .we_in       (we_in),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_we      (bus_we),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int held;
    int pulses;

    clk      = 1'b0;
    reset    = 1'b1;
    req      = 4'b1111;
    lock     = 4'b0000;
    we_in    = 4'b0100;
    addr_in  = {16'h4443, 16'h00A5, 16'h2221, 16'h1110};
    wdata_in = {16'hBBBC, 16'hFF5A, 16'hDDDE, 16'hEEEF};

    // 1: reset held with all requests up
    tick(); tick();
    check("rst_gnt",     32'(gnt), 32'h0);
    check("rst_busy",    32'(busy), 32'h0);
    check("rst_addr",    32'(bus_addr), 32'h0);
    check("rst_we",      32'(bus_we), 32'h0);
    check("rst_timeout", 32'(timeout_err), 32'h0);
    check("rst_gnt_id",  32'(gnt_id), 32'h0);
    reset = 1'b0;
    tick();
    check("first_gnt",   32'(gnt), 32'h1);
    check("first_addr",  32'(bus_addr), 32'h1110);
    check("first_wdata", 32'(bus_wdata), 32'hEEEF);

    // 2: single request from IDLE
    req = 4'b0000;
    tick();
    check("rel_turn_gnt",  32'(gnt), 32'h0);
    check("rel_turn_addr", 32'(bus_addr), 32'h0);
    tick();
    req = 4'b0100;
    tick();
    check("t2_gnt",    32'(gnt), 32'h4);
    check("t2_gnt_id", 32'(gnt_id), 32'h2);
    check("t2_addr",   32'(bus_addr), 32'h00A5);
    check("t2_we",     32'(bus_we), 32'h1);
    req = 4'b0000;
    tick();
    check("t2_turn_we", 32'(bus_we), 32'h0);

    // 3: round robin, each owner releases after 3 granted cycles
    reset_pulse();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t3_owner", 32'(gnt), 32'(1) << order[k]);
      tick();
      tick();
      check("t3_hold", 32'(gnt), 32'(1) << order[k]);
      req[order[k]] = 1'b0;
      tick();
      check("t3_turn", 32'(gnt), 32'h0);
      check("t3_turn_timeout", 32'(timeout_err), 32'h0);
      req[order[k]] = 1'b1;
      tick();
    end

    // 4: timeout preemption of owner 1 by pending master 3
    reset_pulse();
    req = 4'b0010;
    tick();
    check("t4_owner", 32'(gnt), 32'h2);
    req = 4'b1010;
    held = 1;
    pulses = 0;
    for (int c = 2; c <= 16; c++) begin
      tick();
      if (gnt == 4'b0010) held++;
      if (timeout_err) pulses++;
    end
    check("t4_held",   32'(held), 32'd16);
    check("t4_nopulse", 32'(pulses), 32'd0);
    tick();
    check("t4_drop_gnt", 32'(gnt), 32'h0);
    check("t4_pulse",    32'(timeout_err), 32'h1);
    tick();
    check("t4_new_gnt",  32'(gnt), 32'h8);
    check("t4_new_id",   32'(gnt_id), 32'h3);
    check("t4_pulse_end", 32'(timeout_err), 32'h0);

    // 5: locked owner is not preempted until lock drops
    reset_pulse();
    req  = 4'b0010;
    lock = 4'b0010;
    tick();
    req = 4'b1010;
    held = 0;
    pulses = 0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (gnt == 4'b0010) held++;
      if (timeout_err) pulses++;
    end
    check("t5_held",    32'(held), 32'd45);
    check("t5_nopulse", 32'(pulses), 32'd0);
    lock = 4'b0000;
    tick();
    check("t5_drop_gnt", 32'(gnt), 32'h0);
    check("t5_pulse",    32'(timeout_err), 32'h1);
    tick();
    check("t5_new_gnt",  32'(gnt), 32'h8);

    // 6: lone owner never preempted, then async reset mid-grant
    reset_pulse();
    req = 4'b0100;
    tick();
    held = 0;
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (gnt == 4'b0100) held++;
      if (timeout_err) pulses++;
    end
    check("t6_held",    32'(held), 32'd50);
    check("t6_nopulse", 32'(pulses), 32'd0);
    check("t6_we_pre",  32'(bus_we), 32'h1);
    req = 4'b1111;
    reset = 1'b1;
    #1;
    check("t6_async_gnt",  32'(gnt), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    check("t6_async_we",   32'(bus_we), 32'h0);
    check("t6_async_to",   32'(timeout_err), 32'h0);
    reset = 1'b0;
    tick();
    check("t6_after_gnt", 32'(gnt), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
